reg_writeback: RTL and testbench
================================

# reg_writeback

Writeback stage of the XM23 FPGA pipeline: an execute-to-writeback (E/W) pipeline register plus the 8×16 general register file and its constant row. It consumes the 16-bit results produced by the execute units, including the move unit's MOVL/MOVLZ/MOVLS/MOVH result. It commits each result one cycle after capture and drives the `gprc` read array those units consume. An optional bypass makes a pending write visible before it commits.

## Interface
- No parameters; sizes fixed by the XM23 ISA (8 registers, 16 bits).
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `stall_i` in 1: hold the E/W register and suppress commit this cycle.
- `flush_i` in 1: discard the incoming execute result (bubble into E/W).
- `wb_en_i` in 1: execute result valid and targets a register.
- `wb_byte_i` in 1: byte op; write bits [7:0] only.
- `dst_i` in 3: destination register index.
- `result_i` in 16: execute result.
- `gprc` out [1:0][7:0][15:0]: row 0 = register file (bypassed per config); row 1 = constant table.
- `pc_wr_o` out 1: one-cycle pulse, R7 was committed on the previous edge.
- `pc_val_o` out 16: current committed R7 (never bypassed).

## Operation
- E/W register fields: `w_valid`, `w_byte`, `w_dst`, `w_data`.
- Each rising edge, in priority order:
  - `rst`: all 8 registers = 0x0000, `w_valid`=0, `w_byte`=0, `w_dst`=0, `w_data`=0, `pc_wr_o`=0.
  - `stall_i`=1: E/W register holds, no commit, `pc_wr_o` <= 0.
  - Otherwise:
    - If `w_valid`: commit `w_data` to `w_dst`. When `w_byte`=1, only [7:0] is written and [15:8] is kept.
    - Load E/W with `w_valid` <= `wb_en_i & ~flush_i`; other fields load unconditionally.
    - `pc_wr_o` <= `w_valid & (w_dst==7)`.
- `flush_i` never cancels the instruction already in E/W; that instruction is older and always commits.
- `stall_i` together with `flush_i`: stall wins. E/W holds, and the flushed execute result is not captured.
- Constant row `gprc[1]` = {0, 1, 2, 4, 8, 16, 32, 0xFFFF} for indices 0..7; combinational and unaffected by reset.
- `pc_val_o` = committed R7, always.

## Timing
- Result presented with `wb_en_i` in cycle N (no stall) → captured at end of N → committed at end of N+1 → visible in unbypassed `gprc[0]` in N+2.
- With bypass: visible in `gprc[0]` in N+1.
- Back-to-back writes to the same register commit in order; the later one wins.
- A stall in cycle N+1 delays the commit by exactly one cycle per stalled cycle.
- Reset mid-operation discards a pending E/W write; that write is never committed.
- `pc_wr_o` is high in N+2 for a non-stalled write to R7.

## Configuration
- `WB_BYPASS_EN` defined:
  - While `w_valid`=1, `gprc[0][w_dst]` shows the merged value: full `w_data`, or {reg[15:8], `w_data`[7:0]} when `w_byte`=1.
  - This holds during stall too.
  - All other entries show committed contents.
- `WB_BYPASS_EN` undefined: `gprc[0]` shows committed contents only. The upstream hazard logic must stall one extra cycle.
- `pc_val_o` is identical in both builds.

## Structure
- Shared package `xm23_pkg`:
  - `REG_PC`=7, `REG_SP`=6, `REG_LR`=5.
  - The 8-entry constant table.
  - Typedef `reg_t` = logic [15:0].
  - Typedef `wb_req_t` = {valid, byte, dst, data}.
- Sub-module `regfile_bank`:
  - 8×16 storage with a synchronous write port (enable, index, data, byte-only flag).
  - Synchronous active-high reset.
  - Exposes all 8 registers combinationally.
- Top level holds the E/W register, the commit and `pc_wr_o` logic, the bypass mux, and the constant row.

## Test plan
- Reset, then idle → all `gprc[0]` = 0x0000, `gprc[1]` = {0,1,2,4,8,16,32,0xFFFF}, `pc_wr_o`=0, `pc_val_o`=0.
- `wb_en_i`=1, `dst_i`=3, `result_i`=0x12AB at cycle N → R3 = 0x12AB in `gprc[0]` at N+2 (N+1 with bypass).
- R2=0xBEEF, then byte write `dst_i`=2, `result_i`=0x0034 → R2 = 0xBE34.
- Write R4=0x1111 at N with `stall_i`=1 at N+1 and N+2 → commit at end of N+3; same bypassed value visible throughout the stall.
- Write R5=0x0005 at N, then at N+1 `flush_i`=1 with `wb_en_i`=1 for R5=0x9999 → R5 = 0x0005, and 0x9999 never appears.
- Write R7=0x0400 at N → `pc_wr_o` pulses high for exactly cycle N+2, `pc_val_o`=0x0400. Asserting `rst` instead at N+1 leaves R7 = 0 and no pulse.

Source files
------------

// File: rtl/xm23_pkg.sv
// rtl/xm23_pkg.sv - XM23 shared register indices, constant row and writeback request types
package xm23_pkg;

    localparam logic [2:0] REG_PC = 3'd7;
    localparam logic [2:0] REG_SP = 3'd6;
    localparam logic [2:0] REG_LR = 3'd5;

    typedef logic [15:0] reg_t;

    // Constant row, element i is the constant for index i.
    localparam logic [7:0][15:0] CONST_ROW = {
        16'hFFFF, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd0
    };

    typedef struct packed {
        logic       valid;
        logic       is_byte;
        logic [2:0] dst;
        reg_t       data;
    } wb_req_t;

endpackage

// File: rtl/reg_writeback_if.sv
// rtl/reg_writeback_if.sv - execute-to-writeback request bundle
interface reg_writeback_if;
    logic        stall_i;
    logic        flush_i;
    logic        wb_en_i;
    logic        wb_byte_i;
    logic [2:0]  dst_i;
    logic [15:0] result_i;

    modport master (output stall_i, flush_i, wb_en_i, wb_byte_i, dst_i, result_i);
    modport slave  (input  stall_i, flush_i, wb_en_i, wb_byte_i, dst_i, result_i);
endinterface

// File: rtl/regfile_bank.sv
// rtl/regfile_bank.sv - 8x16 general register storage with one synchronous write port
module regfile_bank
    import xm23_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic             is_byte,
    input  logic [2:0]       idx,
    input  reg_t             data,
    output logic [7:0][15:0] regs
);

    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '0;
        end else if (we) begin
            if (is_byte) begin
                regs[idx][7:0] <= data[7:0];
            end else begin
                regs[idx] <= data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// rtl/reg_writeback.sv - XM23 E/W pipeline register, register file commit and gprc read array; WB_BYPASS_EN exposes the pending write early
module reg_writeback
    import xm23_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    reg_writeback_if.slave        wb,
    output logic [1:0][7:0][15:0] gprc,
    output logic                  pc_wr_o,
    output logic [15:0]           pc_val_o
);

    wb_req_t          w_q;
    logic [7:0][15:0] regs;
    logic             commit;

    // The instruction held in E/W is older than any flush, so only a stall blocks it.
    assign commit = w_q.valid & ~wb.stall_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_q     <= '0;
            pc_wr_o <= 1'b0;
        end else if (wb.stall_i) begin
            pc_wr_o <= 1'b0;
        end else begin
            w_q.valid   <= wb.wb_en_i & ~wb.flush_i;
            w_q.is_byte <= wb.wb_byte_i;
            w_q.dst     <= wb.dst_i;
            w_q.data    <= wb.result_i;
            pc_wr_o     <= w_q.valid && (w_q.dst == REG_PC);
        end
    end

    regfile_bank u_bank (
        .clk     (clk),
        .rst     (rst),
        .we      (commit),
        .is_byte (w_q.is_byte),
        .idx     (w_q.dst),
        .data    (w_q.data),
        .regs    (regs)
    );

    always_comb begin
        gprc[1] = CONST_ROW;
        gprc[0] = regs;
`ifdef WB_BYPASS_EN
        if (w_q.valid) begin
            gprc[0][w_q.dst] = w_q.is_byte ? {regs[w_q.dst][15:8], w_q.data[7:0]} : w_q.data;
        end
`endif
    end

    assign pc_val_o = regs[REG_PC];

endmodule

// File: tb/tb_reg_writeback.sv
// tb/tb_reg_writeback.sv - scoreboard bench for reg_writeback, expectations queued per cycle
module tb_reg_writeback;

`ifdef WB_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0][7:0][15:0] gprc;
    logic                  pc_wr_o;
    logic [15:0]           pc_val_o;

    reg_writeback_if wb ();

    reg_writeback dut (
        .clk      (clk),
        .rst      (rst),
        .wb       (wb),
        .gprc     (gprc),
        .pc_wr_o  (pc_wr_o),
        .pc_val_o (pc_val_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int          at;
        int          kind;
        int          idx;
        logic [15:0] val;
        string       name;
    } chk_t;

    chk_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic logic [15:0] sample(int kind, int idx);
        case (kind)
            0:       return gprc[0][idx];
            1:       return gprc[1][idx];
            2:       return {15'd0, pc_wr_o};
            default: return pc_val_o;
        endcase
    endfunction

    always @(negedge clk) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].at <= cyc) begin
                logic [15:0] got;
                got = sample(q[i].kind, q[i].idx);
                n_vec++;
                if (q[i].at < cyc) begin
                    n_bad++;
                    $display("FAIL %s: check for cycle %0d missed at cycle %0d", q[i].name, q[i].at, cyc);
                end else if (got !== q[i].val) begin
                    n_bad++;
                    $display("FAIL %s @%0d: got %h expected %h", q[i].name, cyc, got, q[i].val);
                end
                q.delete(i);
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic put(logic s, logic f, logic e, logic b, logic [2:0] d, logic [15:0] r);
        wb.stall_i   = s;
        wb.flush_i   = f;
        wb.wb_en_i   = e;
        wb.wb_byte_i = b;
        wb.dst_i     = d;
        wb.result_i  = r;
    endtask

    task automatic idle();
        put(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
    endtask

    task automatic exp(int at, int kind, int idx, logic [15:0] val, string name);
        chk_t c;
        c.at = at; c.kind = kind; c.idx = idx; c.val = val; c.name = name;
        q.push_back(c);
    endtask

    initial begin
        int n;
        logic [7:0][15:0] consts;
        consts = {16'hFFFF, 16'd32, 16'd16, 16'd8, 16'd4, 16'd2, 16'd1, 16'd0};

        rst = 1'b1;
        idle();
        next();
        next();
        rst = 1'b0;

        // reset state
        n = cyc;
        for (int i = 0; i < 8; i++) begin
            exp(n, 0, i, 16'h0000, $sformatf("rst_r%0d", i));
            exp(n, 1, i, consts[i], $sformatf("const%0d", i));
        end
        exp(n, 2, 0, 16'h0000, "rst_pc_wr");
        exp(n, 3, 0, 16'h0000, "rst_pc_val");
        next();

        // basic write R3
        n = cyc;
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'h12AB);
        exp(n + LAT - 1, 0, 3, 16'h0000, "r3_before");
        exp(n + LAT,     0, 3, 16'h12AB, "r3_visible");
        exp(n + LAT + 2, 0, 3, 16'h12AB, "r3_held");
        next();
        idle();
        repeat (4) next();

        // full write then byte write to R2, back-to-back
        n = cyc;
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'hBEEF);
        exp(n + LAT,     0, 2, 16'hBEEF, "r2_full");
        exp(n + LAT + 1, 0, 2, 16'hBE34, "r2_byte");
        next();
        put(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'h0034);
        next();
        idle();
        repeat (4) next();

        // back-to-back same register, later wins
        n = cyc;
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h1111);
        exp(n + LAT,     0, 1, 16'h1111, "r1_first");
        exp(n + LAT + 1, 0, 1, 16'h2222, "r1_second");
        exp(n + LAT + 3, 0, 1, 16'h2222, "r1_final");
        next();
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd1, 16'h2222);
        next();
        idle();
        repeat (5) next();

        // R4 with two stall cycles; stall+flush input is dropped
        n = cyc;
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 16'h1111);
        for (int k = 1; k <= 3; k++)
            exp(n + k, 0, 4, (LAT == 1) ? 16'h1111 : 16'h0000, $sformatf("r4_stall%0d", k));
        exp(n + 4, 0, 4, 16'h1111, "r4_commit");
        exp(n + 6, 0, 4, 16'h1111, "r4_no_7777");
        next();
        put(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000);
        next();
        put(1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 16'h7777);
        next();
        idle();
        repeat (5) next();

        // flush of the younger R5 write
        n = cyc;
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0005);
        for (int k = 1; k <= 5; k++)
            exp(n + k, 0, 5, (k >= LAT) ? 16'h0005 : 16'h0000, $sformatf("r5_flush%0d", k));
        next();
        put(1'b0, 1'b1, 1'b1, 1'b0, 3'd5, 16'h9999);
        next();
        idle();
        repeat (5) next();

        // R7 write: pc_wr pulse and pc_val
        n = cyc;
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0400);
        exp(n + 1, 2, 0, 16'h0000, "pc_wr_n1");
        exp(n + 2, 2, 0, 16'h0001, "pc_wr_n2");
        exp(n + 3, 2, 0, 16'h0000, "pc_wr_n3");
        exp(n + 1, 3, 0, 16'h0000, "pc_val_n1");
        exp(n + 2, 3, 0, 16'h0400, "pc_val_n2");
        exp(n + LAT, 0, 7, 16'h0400, "r7_visible");
        next();
        idle();
        repeat (5) next();

        // R7 write killed by reset
        n = cyc;
        put(1'b0, 1'b0, 1'b1, 1'b0, 3'd7, 16'h0800);
        exp(n + 2, 2, 0, 16'h0000, "rst_pc_wr_n2");
        exp(n + 3, 2, 0, 16'h0000, "rst_pc_wr_n3");
        exp(n + 2, 3, 0, 16'h0000, "rst_pc_val");
        exp(n + 3, 0, 7, 16'h0000, "rst_r7");
        exp(n + 3, 0, 3, 16'h0000, "rst_r3");
        exp(n + 3, 0, 4, 16'h0000, "rst_r4");
        next();
        idle();
        rst = 1'b1;
        next();
        rst = 1'b0;
        repeat (4) next();

        for (int k = 0; k < 20 && q.size() > 0; k++) next();
        if (q.size() > 0) begin
            n_bad += q.size();
            $display("FAIL drain: %0d checks left, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
